// File: rtl/cd_tx_sched_pkg.sv
// cd_pkg: shared state encoding, CSR map defaults and count width for the TX scheduler
package cd_pkg;
  localparam logic [2:0] S_INIT     = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_POLL_RD  = 3'd2;
  localparam logic [2:0] S_POLL_CHK = 3'd3;
  localparam logic [2:0] S_STREAM   = 3'd4;
  localparam logic [2:0] S_DRAIN    = 3'd5;
  localparam logic [2:0] S_COMMIT   = 3'd6;
  localparam logic [4:0] REG_TX_D       = 5'h0A;
  localparam logic [4:0] REG_TX_CTRL_D  = 5'h0B;
  localparam logic [4:0] REG_INT_FLAG_D = 5'h10;
  localparam int         FLAG_TX_FREE_D = 5;
  localparam logic [7:0] CTRL_COMMIT_D  = 8'h01;
  localparam logic [7:0] CTRL_ABORT_D   = 8'h04;
  localparam int         MAX_LEN_D      = 256;
  localparam int         CNT_W          = $clog2(MAX_LEN_D + 1);
  localparam logic [15:0] POLL_MAX_D    = 16'hFFFF;
endpackage

// File: rtl/cd_tx_sched_if.sv
// cd_tx_sched_if: 8-bit CSR bus between the scheduler (master) and the CDBUS core (slave)
//   address/read/write/writedata driven by master, readdata returned by slave one cycle after read
interface cd_tx_sched_if;
  logic [4:0] address;
  logic       read;
  logic [7:0] readdata;
  logic       write;
  logic [7:0] writedata;
  modport master (output address, read, write, writedata, input readdata);
  modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/cd_tx_sched_arb.sv
// cd_rr_arb: combinational requester picker, round-robin after i_last_grant or strict priority
//   i_req: pending requests, i_last_grant: previous winner
//   o_grant_valid: any request pending, o_grant_idx: winner
//   CD_TX_SCHED_PRIO_EN defined selects lowest-index-wins priority
module cd_rr_arb import cd_pkg::*; #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [1:0]       i_last_grant,
  output logic             o_grant_valid,
  output logic [1:0]       o_grant_idx
);
  always_comb begin
    o_grant_valid = |i_req;
    o_grant_idx = '0;
`ifdef CD_TX_SCHED_PRIO_EN
    for (int k = N_REQ - 1; k >= 0; k--)
      if (|(i_req & (N_REQ'(1) << k))) o_grant_idx = 2'(k);
`else
    // scan farthest offset first so the nearest requester after the last grant wins
    for (int k = N_REQ; k >= 1; k--)
      if (|(i_req & (N_REQ'(1) << ((int'(i_last_grant) + k) % N_REQ))))
        o_grant_idx = 2'((int'(i_last_grant) + k) % N_REQ);
`endif
  end
endmodule

// File: rtl/cd_tx_sched.sv
// cd_tx_sched: shares one CDBUS TX buffer between N_REQ byte-stream requesters via CSR writes
//   clk, reset_n (async active-low)
//   req_valid/req_data/req_last/req_ready: per-requester byte streams
//   csr: CSR bus master (cd_tx_sched_if.master)
//   grant_id: current/last winner, busy: not idle, done/err: commit/abort pulses
//   CD_TX_SCHED_PRIO_EN (in cd_rr_arb) switches round-robin to strict priority
module cd_tx_sched import cd_pkg::*; #(
  parameter int          N_REQ        = 2,
  parameter logic [4:0]  REG_TX       = REG_TX_D,
  parameter logic [4:0]  REG_TX_CTRL  = REG_TX_CTRL_D,
  parameter logic [4:0]  REG_INT_FLAG = REG_INT_FLAG_D,
  parameter int          FLAG_TX_FREE = FLAG_TX_FREE_D,
  parameter logic [7:0]  CTRL_COMMIT  = CTRL_COMMIT_D,
  parameter logic [7:0]  CTRL_ABORT   = CTRL_ABORT_D,
  parameter int          MAX_LEN      = MAX_LEN_D,
  parameter logic [15:0] POLL_MAX     = POLL_MAX_D
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  cd_tx_sched_if.master        csr,
  output logic [1:0]           grant_id,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  logic [2:0] r_state, w_next;
  logic [1:0] r_grant, w_gidx;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0] r_poll;
  logic r_busy, r_done, r_err, r_rd, r_wr;
  logic [4:0] r_addr;
  logic [7:0] r_wdata, w_byte;
  logic [N_REQ-1:0] w_oh;
  logic w_gv, w_acc, w_last, w_full, w_flag, w_wr_tx, w_commit, w_abort;
  cd_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .i_req(req_valid), .i_last_grant(r_grant), .o_grant_valid(w_gv), .o_grant_idx(w_gidx)
  );
  assign w_oh = N_REQ'(1) << r_grant;
  assign req_ready = (r_state == S_STREAM || r_state == S_DRAIN) ? w_oh : '0;
  assign w_acc = |(req_valid & req_ready);
  assign w_last = |(req_last & w_oh);
  assign w_byte = 8'(req_data >> {r_grant, 3'b000});
  assign w_full = r_cnt == CNT_W'(MAX_LEN);
  assign w_flag = csr.readdata[FLAG_TX_FREE];
  assign w_wr_tx = r_state == S_STREAM && w_acc && !w_full;
  assign w_commit = r_state == S_COMMIT;
  // a last byte arriving when the buffer is already full aborts straight away
  assign w_abort = r_state == S_INIT || (w_acc && w_last && (r_state == S_DRAIN || w_full));
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:     w_next = S_IDLE;
      S_IDLE:     w_next = w_gv ? S_POLL_RD : S_IDLE;
      S_POLL_RD:  w_next = S_POLL_CHK;
      S_POLL_CHK: w_next = w_flag ? S_STREAM : (r_poll == POLL_MAX - 16'd1) ? S_DRAIN : S_POLL_RD;
      S_STREAM:   w_next = !w_acc ? S_STREAM : w_full ? (w_last ? S_IDLE : S_DRAIN) : (w_last ? S_COMMIT : S_STREAM);
      S_DRAIN:    w_next = (w_acc && w_last) ? S_IDLE : S_DRAIN;
      default:    w_next = S_IDLE;
    endcase
  end
  // CSR strobes are registered so every access is a clean single-cycle pulse and reset drives them low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_INIT;
      r_grant <= 2'(N_REQ - 1);
      r_cnt <= '0;
      r_poll <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_rd <= 1'b0;
      r_wr <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_grant <= (r_state == S_IDLE && w_gv) ? w_gidx : r_grant;
      r_cnt <= (w_next == S_IDLE) ? '0 : w_wr_tx ? r_cnt + 1'b1 : r_cnt;
      r_poll <= (w_next == S_IDLE) ? '0 : (r_state == S_POLL_CHK && !w_flag) ? r_poll + 16'd1 : r_poll;
      r_busy <= w_next != S_IDLE;
      r_done <= w_commit;
      r_err <= w_abort && r_state != S_INIT;
      r_rd <= w_next == S_POLL_RD;
      r_wr <= w_wr_tx || w_abort || w_commit;
      r_addr <= (w_next == S_POLL_RD) ? REG_INT_FLAG : w_wr_tx ? REG_TX : (w_abort || w_commit) ? REG_TX_CTRL : 5'd0;
      r_wdata <= w_wr_tx ? w_byte : w_commit ? CTRL_COMMIT : w_abort ? CTRL_ABORT : 8'd0;
    end
  end
  assign csr.address = r_addr;
  assign csr.read = r_rd;
  assign csr.write = r_wr;
  assign csr.writedata = r_wdata;
  assign grant_id = r_grant;
  assign busy = r_busy;
  assign done = r_done;
  assign err = r_err;
endmodule

// File: tb/tb_cd_tx_sched.sv
// tb_cd_tx_sched: randomized frame traffic against a frame-level reference model of the scheduler
module tb_cd_tx_sched;
  import cd_pkg::*;
  localparam int N = 2;
  localparam logic [15:0] PMAX = 16'd20;
  localparam int MLEN = 256;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [8*N-1:0] req_data = '0;
  logic [1:0] grant_id;
  logic busy, done, err;
  cd_tx_sched_if csr();
  cd_tx_sched #(.N_REQ(N), .POLL_MAX(PMAX)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .csr(csr), .grant_id(grant_id),
    .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask
  logic [8:0] sq[N][$], rq[N][$], mq[N][$];
  int zq[$];
  logic [12:0] exp_w[$], obs_w[$];
  logic [2:0] exp_ev[$], obs_ev[$];
  int exp_reads, obs_reads = 0, m_last = N - 1;
  int cyc = 0, last_wcyc = 0, fi_s = 0, polls_f = 0, viol = 0;
  logic [N-1:0] acc_v;
  logic [7:0] rd_v;
  always @(posedge clk) cyc++;
  initial begin
    forever begin
      @(posedge clk);
      acc_v = req_valid & req_ready;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (acc_v[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        req_valid[i] = rq[i].size() > 0;
        req_last[i] = rq[i].size() > 0 ? rq[i][0][8] : 1'b0;
        req_data[8*i +: 8] = rq[i].size() > 0 ? rq[i][0][7:0] : 8'h00;
      end
    end
  end
  always @(negedge clk) begin
    if (csr.read && csr.write) viol++;
    if (done && err) viol++;
    if (csr.read) begin
      rd_v = 8'($urandom);
      rd_v[FLAG_TX_FREE_D] = polls_f >= (fi_s < zq.size() ? zq[fi_s] : 0);
      csr.readdata = rd_v;
      polls_f++;
      obs_reads++;
    end
    if (csr.write) begin
      if (csr.address == REG_TX_CTRL_D && csr.writedata == CTRL_COMMIT_D) chk("commit_adj", cyc - last_wcyc, 1);
      obs_w.push_back({csr.address, csr.writedata});
      last_wcyc = cyc;
    end
    if (done || err) begin
      obs_ev.push_back({err, grant_id});
      fi_s++;
      polls_f = 0;
    end
  end
  task automatic build_exp();
    int g, fi, z, lg;
    logic [8:0] b;
    logic [7:0] fr[$];
    lg = m_last;
    fi = 0;
    exp_w.delete();
    exp_ev.delete();
    exp_reads = 0;
    for (int i = 0; i < N; i++) mq[i] = sq[i];
    while (1) begin
      g = -1;
`ifdef CD_TX_SCHED_PRIO_EN
      for (int k = N - 1; k >= 0; k--) if (mq[k].size() > 0) g = k;
`else
      for (int k = N; k >= 1; k--) if (mq[(lg + k) % N].size() > 0) g = (lg + k) % N;
`endif
      if (g < 0) break;
      fr.delete();
      do begin
        b = mq[g].pop_front();
        fr.push_back(b[7:0]);
      end while (!b[8]);
      z = fi < zq.size() ? zq[fi] : 0;
      if (z >= int'(PMAX)) begin
        exp_reads += int'(PMAX);
        exp_w.push_back({REG_TX_CTRL_D, CTRL_ABORT_D});
        exp_ev.push_back({1'b1, 2'(g)});
      end else begin
        exp_reads += z + 1;
        for (int k = 0; k < fr.size() && k < MLEN; k++) exp_w.push_back({REG_TX_D, fr[k]});
        if (fr.size() > MLEN) begin
          exp_w.push_back({REG_TX_CTRL_D, CTRL_ABORT_D});
          exp_ev.push_back({1'b1, 2'(g)});
        end else begin
          exp_w.push_back({REG_TX_CTRL_D, CTRL_COMMIT_D});
          exp_ev.push_back({1'b0, 2'(g)});
        end
      end
      lg = g;
      fi++;
    end
    m_last = lg;
  endtask
  task automatic add_frame(input int r, input int len);
    for (int k = 0; k < len; k++) sq[r].push_back({k == len - 1, 8'($urandom)});
  endtask
  task automatic run_phase(input string nm);
    build_exp();
    obs_w.delete();
    obs_ev.delete();
    obs_reads = 0;
    fi_s = 0;
    polls_f = 0;
    for (int i = 0; i < N; i++) begin
      rq[i] = sq[i];
      sq[i].delete();
    end
    for (int t = 0; t < 20000 && obs_ev.size() < exp_ev.size(); t++) @(negedge clk);
    repeat (6) @(negedge clk);
    chk({nm, "_frames"}, obs_ev.size(), exp_ev.size());
    for (int k = 0; k < exp_ev.size() && k < obs_ev.size(); k++) chk({nm, "_ev"}, obs_ev[k], exp_ev[k]);
    chk({nm, "_nwr"}, obs_w.size(), exp_w.size());
    for (int k = 0; k < exp_w.size() && k < obs_w.size(); k++) chk({nm, "_wr"}, obs_w[k], exp_w[k]);
    chk({nm, "_reads"}, obs_reads, exp_reads);
    chk({nm, "_idle"}, {busy, req_ready}, 0);
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_outs"}, {csr.read, csr.write, csr.address, csr.writedata, busy, done, err, req_ready}, 0);
    chk({nm, "_grant"}, grant_id, N - 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_reset("rst");
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("init_nwr", obs_w.size(), 1);
    chk("init_wr", obs_w.size() > 0 ? obs_w[0] : 13'h0, {REG_TX_CTRL_D, CTRL_ABORT_D});
    chk("init_reads", obs_reads, 0);
    sq[0].push_back(9'h011);
    sq[0].push_back(9'h022);
    sq[0].push_back(9'h133);
    zq = {0};
    run_phase("single");
    chk("single_grant", grant_id, 0);
    add_frame(0, 4);
    zq = {5};
    run_phase("poll5");
    for (int k = 0; k < 2; k++) begin
      add_frame(0, 2);
      add_frame(1, 2);
    end
    zq.delete();
    for (int k = 0; k < 4; k++) zq.push_back($urandom_range(0, 3));
    run_phase("rr");
    add_frame(0, 258);
    add_frame(0, 256);
    add_frame(1, 5);
    add_frame(1, 3);
    zq = {0, int'(PMAX), 1, 0};
    run_phase("long");
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < N; i++)
        for (int f = $urandom_range(0, 3); f > 0; f--) add_frame(i, $urandom_range(1, 6));
      zq.delete();
      for (int k = 0; k < 8; k++) zq.push_back($urandom_range(0, 9) == 0 ? int'(PMAX) : $urandom_range(0, 3));
      run_phase("rand");
    end
    add_frame(1, 40);
    zq = {0};
    obs_w.delete();
    fi_s = 0;
    polls_f = 0;
    rq[1] = sq[1];
    sq[1].delete();
    for (int t = 0; t < 200 && obs_w.size() < 5; t++) @(negedge clk);
    chk("mid_stream", obs_w.size() >= 5, 1);
    #2 reset_n = 1'b0;
    #1 chk_reset("async_rst");
    for (int i = 0; i < N; i++) rq[i].delete();
    repeat (3) @(negedge clk);
    chk_reset("held_rst");
    obs_w.delete();
    obs_reads = 0;
    reset_n = 1'b1;
    m_last = N - 1;
    for (int t = 0; t < 10 && obs_w.size() == 0 && obs_reads == 0; t++) @(negedge clk);
    chk("post_rst_wr", obs_w.size() > 0 ? obs_w[0] : 13'h0, {REG_TX_CTRL_D, CTRL_ABORT_D});
    chk("post_rst_rd", obs_reads, 0);
    add_frame(0, 3);
    add_frame(1, 2);
    add_frame(1, 1);
    zq = {1, 0, 2};
    run_phase("after_rst");
    chk("rw_excl", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
